// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin core/aux arbiter for the single-port data memory, with aux bus lock (optional DMEM_ARB_BOUNDS_CHECK_EN)
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LOCK_TIMEOUT = 16,
  parameter int MEM_WORDS    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  input  logic              aux_lock,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  output logic              bounds_err,
`endif
  output logic              lock_err
);
  localparam logic [0:0] ARB    = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  localparam logic [0:0] CORE   = 1'b0;
  localparam logic [0:0] AUX    = 1'b1;
  if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 255 || MEM_WORDS < 1) begin : g_bad_param
    $error("dmem_arbiter: LOCK_TIMEOUT must be 1..255 and MEM_WORDS >= 1");
  end
  logic [0:0]        state_q, state_d;
  logic [0:0]        last_gnt_q, last_gnt_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic              lock_err_q, lock_err_d;
  logic              relock_blk_q, relock_blk_d;
  logic              core_rvalid_q, core_rvalid_d;
  logic              aux_rvalid_q, aux_rvalid_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;
  logic              any_gnt;
  logic              oob;
  logic              timeout;
  logic              locked;
  assign locked  = state_q == LOCKED;
  assign any_gnt = core_gnt | aux_gnt;
  assign timeout = locked && aux_lock && lock_cnt_q == 8'(LOCK_TIMEOUT);
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  logic bounds_err_q, bounds_err_d;
  assign oob          = any_gnt && (mem_address >= ADDR_W'(MEM_WORDS));
  assign bounds_err_d = bounds_err_q | oob;
  assign bounds_err   = bounds_err_q;
  // sticky out-of-range access flag
  always_ff @(posedge clk) begin
    if (!rst_n) bounds_err_q <= 1'b0;
    else bounds_err_q <= bounds_err_d;
  end
`else
  assign oob = 1'b0;
`endif
  // grant from requests and registered state; winner's fields steer the memory port
  always_comb begin
    core_gnt    = !locked && core_req && (!aux_req || last_gnt_q == AUX);
    aux_gnt     = aux_req && (locked || !core_req || last_gnt_q == CORE);
    mem_address = aux_gnt ? aux_addr : core_gnt ? core_addr : '0;
    mem_wdata   = aux_gnt ? aux_wdata : core_gnt ? core_wdata : '0;
    mem_write   = (aux_gnt ? aux_we : core_gnt && core_we) && !oob;
    mem_read    = (aux_gnt ? !aux_we : core_gnt && !core_we) && !oob;
  end
  // arbitration state, lock tracking and read-return capture
  always_comb begin
    state_d       = state_q;
    last_gnt_d    = core_gnt ? CORE : aux_gnt ? AUX : last_gnt_q;
    lock_cnt_d    = lock_cnt_q;
    lock_err_d    = lock_err_q | timeout;
    relock_blk_d  = timeout | (relock_blk_q & aux_lock);
    core_rvalid_d = core_gnt && !core_we;
    aux_rvalid_d  = aux_gnt && !aux_we;
    core_rdata_d  = core_rvalid_d ? (oob ? '0 : mem_rdata) : core_rdata_q;
    aux_rdata_d   = aux_rvalid_d ? (oob ? '0 : mem_rdata) : aux_rdata_q;
    if (!locked) begin
      state_d    = (aux_gnt && aux_lock && !relock_blk_q) ? LOCKED : ARB;
      lock_cnt_d = (aux_gnt && aux_lock && !relock_blk_q) ? 8'd1 : 8'd0;
    end else begin
      state_d    = (!aux_lock || timeout) ? ARB : LOCKED;
      lock_cnt_d = (!aux_lock || timeout) ? 8'd0 : lock_cnt_q + 8'd1;
      last_gnt_d = (!aux_lock || timeout) ? AUX : last_gnt_d;
    end
  end
  // state registers; reset cancels pending returns, drops the lock and clears lock_err
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ARB;
      last_gnt_q    <= AUX;
      lock_cnt_q    <= '0;
      lock_err_q    <= 1'b0;
      relock_blk_q  <= 1'b0;
      core_rvalid_q <= 1'b0;
      aux_rvalid_q  <= 1'b0;
      core_rdata_q  <= '0;
      aux_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_gnt_q    <= last_gnt_d;
      lock_cnt_q    <= lock_cnt_d;
      lock_err_q    <= lock_err_d;
      relock_blk_q  <= relock_blk_d;
      core_rvalid_q <= core_rvalid_d;
      aux_rvalid_q  <= aux_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      aux_rdata_q   <= aux_rdata_d;
    end
  end
  assign core_rvalid = core_rvalid_q;
  assign aux_rvalid  = aux_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign aux_rdata   = aux_rdata_q;
  assign lock_err    = lock_err_q;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the single-port data memory.
- Shares the memory between the core load/store path and an auxiliary master (loader/debug/DMA), one access per clock.
- Round-robin on conflict; optional bus lock gives the aux master atomic read-modify-write sequences.
- Read data is returned registered, one cycle after grant.

Parameters:
- ADDR_W, 32, address width (matches the data-memory address port).
- DATA_W, 32, data width.
- LOCK_TIMEOUT, 16, max consecutive cycles aux may hold the lock (range 1..255).
- MEM_WORDS, 32, number of valid memory words (used only by the optional bounds check).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- core_req  in  1  core access request.
- core_we  in  1  1=write, 0=read.
- core_addr  in  ADDR_W  core word address.
- core_wdata  in  DATA_W  core write data.
- core_gnt  out  1  core access issued this cycle.
- core_rvalid  out  1  core_rdata valid this cycle.
- core_rdata  out  DATA_W  registered read data to core.
- aux_req, aux_we, aux_addr, aux_wdata, aux_gnt, aux_rvalid, aux_rdata: same as the core_* ports, for the aux master.
- aux_lock  in  1  aux requests exclusive ownership.
- mem_address  out  ADDR_W  to the memory address input.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory combinational read data.
- lock_err  out  1  sticky; set when a lock is forcibly released by timeout.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=ARB, last_gnt=AUX (core wins the first conflict), lock_cnt=0.
  - core_rvalid=aux_rvalid=0, core_rdata=aux_rdata=0, lock_err=0.
- Grant is combinational from req and the registered state.
  - mem_* are muxed combinationally from the winner's fields.
  - With no winner: mem_write=mem_read=0, mem_address=0, mem_wdata=0.
- Requester rule: hold req/we/addr/wdata stable until a posedge at which its gnt=1. Dropping req before grant is allowed; the access is abandoned.
- State ARB:
  - Only one requester asserts req: it is granted.
  - Both assert req: grant goes to the one that is not last_gnt. last_gnt updates on every grant.
  - Aux granted with aux_lock=1: next state LOCKED, lock_cnt=1.
- State LOCKED:
  - core_gnt=0 regardless of core_req.
  - aux_req granted every cycle it is asserted; lock_cnt increments every cycle.
  - aux_lock=0 at a posedge: back to ARB, last_gnt=AUX.
  - lock_cnt==LOCK_TIMEOUT with aux_lock still 1: forced back to ARB, lock_err<=1, last_gnt=AUX. aux_lock must go low before a new lock can be taken (edge-qualified re-lock).
- Access timing, grant in cycle N:
  - Write: mem_write=1 in cycle N only; the memory commits at that clock.
  - Read: mem_read=1 in cycle N; mem_rdata is captured at the posedge ending N. x_rvalid=1 and x_rdata=captured value in cycle N+1 only.
- x_rdata holds its last value while x_rvalid=0.
- Writes produce no rvalid.
- Back-to-back grants to one master are allowed; one rvalid per read grant, in order.
- Reset mid-operation: pending rvalid is cancelled, the lock is dropped, lock_err is cleared.
- lock_err clears only on reset.

Optional Feature:
- Macro: DMEM_ARB_BOUNDS_CHECK_EN.
- Defined:
  - A granted access with addr >= MEM_WORDS is still granted, but mem_write/mem_read are held 0.
  - A read returns rdata=0 with rvalid=1.
  - Extra output bounds_err (1 bit, sticky, reset 0) is set.
- Undefined:
  - No check is made; addresses pass through unmodified.
  - The bounds_err port does not exist.

Test Plan:
- Reset, then core read of addr 5 (mem holds 0xDEADBEEF) -> core_gnt=1 in the same cycle; next cycle core_rvalid=1, core_rdata=0xDEADBEEF.
- core and aux both request continuously for 4 cycles after reset -> grants alternate core, aux, core, aux; mem_address follows the winner.
- aux write 0x1234 to addr 3, then core read addr 3 the following cycle -> core_rdata=0x00001234.
- aux_lock=1 with 3 aux accesses while core_req=1 -> core_gnt=0 throughout; core granted the cycle after aux_lock drops.
- aux_lock held 20 cycles with LOCK_TIMEOUT=16 -> forced release after the 16th locked cycle, lock_err=1, core granted next.
- With DMEM_ARB_BOUNDS_CHECK_EN, core write to addr 40 (MEM_WORDS=32) -> mem_write=0, bounds_err=1, memory contents unchanged.
